// File: rtl/rect_fill_writer.sv
// rect_fill_writer: fills a clipped, axis-aligned rectangle into the
// 320x240 3-bit bitmap write port, one pixel per clock in raster order.
module rect_fill_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ready,
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] width,
  input  logic [7:0] height,
  input  logic [2:0] fill_color,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] color,
  output logic       wr_en,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_t;

  localparam logic [9:0] W_LIM = 10'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  state_t     state;
  state_t     state_d;

  logic [8:0] x_org;
  logic [8:0] x_org_d;
  logic [9:0] x_end;
  logic [9:0] x_end_d;
  logic [8:0] y_end;
  logic [8:0] y_end_d;

  logic [8:0] x_d;
  logic [7:0] y_d;
  logic [2:0] color_d;
  logic       wr_en_d;
  logic       done_d;

  logic [9:0] x_sum;
  logic [8:0] y_sum;
  logic [9:0] x_clip;
  logic [8:0] y_clip;
  logic       empty;

  logic [9:0] x_nxt;
  logic [8:0] y_nxt;
  logic       row_last;
  logic       last_pix;

  assign ready = (state == IDLE);

  // Clip bounds of the incoming request, kept wide so nothing wraps.
  always_comb begin
    x_sum  = {1'b0, x0} + {1'b0, width};
    y_sum  = {1'b0, y0} + {1'b0, height};
    x_clip = (x_sum < W_LIM) ? x_sum : W_LIM;
    y_clip = (y_sum < H_LIM) ? y_sum : H_LIM;
    empty  = (width == 9'd0)
           | (height == 8'd0)
           | ({1'b0, x0} >= W_LIM)
           | ({1'b0, y0} >= H_LIM);
  end

  // Raster position tests on the pixel currently being presented.
  always_comb begin
    x_nxt    = {1'b0, x} + 10'd1;
    y_nxt    = {1'b0, y} + 9'd1;
    row_last = (x_nxt == x_end);
    last_pix = row_last && (y_nxt == y_end);
  end

  // Next-state and next-output logic; the write port is registered.
  always_comb begin
    state_d = state;
    x_org_d = x_org;
    x_end_d = x_end;
    y_end_d = y_end;
    x_d     = x;
    y_d     = y;
    color_d = color;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          color_d = fill_color;
          x_org_d = x0;
          x_end_d = x_clip;
          y_end_d = y_clip;
          if (empty) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAW;
            x_d     = x0;
            y_d     = y0;
            wr_en_d = 1'b1;
          end
        end
      end
      DRAW: begin
        if (last_pix) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          if (row_last) begin
            x_d = x_org;
            y_d = y_nxt[7:0];
          end else begin
            x_d = x_nxt[8:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Request bounds and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_org <= '0;
      x_end <= '0;
      y_end <= '0;
      x     <= '0;
      y     <= '0;
      color <= '0;
      wr_en <= 1'b0;
      done  <= 1'b0;
    end else begin
      x_org <= x_org_d;
      x_end <= x_end_d;
      y_end <= y_end_d;
      x     <= x_d;
      y     <= y_d;
      color <= color_d;
      wr_en <= wr_en_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_fill_writer.sv
// tb_rect_fill_writer: table vectors, corner sequences and random
// requests checked against a pixel-list model of the clipped rectangle.
module tb_rect_fill_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ready;
  logic [8:0] x0;
  logic [7:0] y0;
  logic [8:0] width;
  logic [7:0] height;
  logic [2:0] fill_color;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       wr_en;
  logic       done;

  rect_fill_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ready      (ready),
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .fill_color (fill_color),
    .x          (x),
    .y          (y),
    .color      (color),
    .wr_en      (wr_en),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } pix_t;

  typedef struct {
    int x0;
    int y0;
    int w;
    int h;
    int c;
    int n;
    int fx;
    int fy;
    int lx;
    int ly;
  } vec_t;

  localparam logic [31:0] CTL   = 32'h0070_0000;
  localparam logic [31:0] ALL   = 32'hFFFF_FFFF;
  localparam logic [31:0] S_IDL = 32'h0010_0000;
  localparam logic [31:0] S_DON = 32'h0020_0000;

  int   nvec = 0;
  int   nerr = 0;
  pix_t exp_q[$];
  int   hits[320][240];
  int   obs_n;
  int   obs_fx;
  int   obs_fy;
  int   obs_lx;
  int   obs_ly;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input logic [31:0] msk);
    nvec++;
    if ((act & msk) !== (exp & msk)) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act & msk, exp & msk);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'b0, wr_en, done, ready, x, y, color};
  endfunction

  // Every on-screen pixel of the requested rectangle, in raster order.
  task automatic model(input int ax0, input int ay0,
                       input int aw, input int ah);
    exp_q.delete();
    for (int yy = ay0; yy < ay0 + ah; yy++)
      for (int xx = ax0; xx < ax0 + aw; xx++)
        if (xx < 320 && yy < 240)
          exp_q.push_back('{xx, yy});
  endtask

  // Issue one request at a negedge with ready high and check every cycle
  // through the ready-return cycle. Optionally re-raise start at cycle pk.
  task automatic run_req(input string tag,
                         input int ax0, input int ay0, input int aw,
                         input int ah, input int ac,
                         input int pk, input int pk_until,
                         input int px0, input int py0, input int pw,
                         input int ph, input int pc);
    int n;
    logic [31:0] e;
    logic [31:0] m;
    model(ax0, ay0, aw, ah);
    n = exp_q.size();
    obs_n = 0;
    chk($sformatf("%s idle", tag), outs(), S_IDL, 32'h0010_0000);
    x0 = 9'(ax0);
    y0 = 8'(ay0);
    width = 9'(aw);
    height = 8'(ah);
    fill_color = 3'(ac);
    start = 1'b1;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        x0 = 9'($urandom);
        y0 = 8'($urandom);
        width = 9'($urandom);
        height = 8'($urandom);
        fill_color = ~fill_color;
      end
      if (k == pk) begin
        start = 1'b1;
        x0 = 9'(px0);
        y0 = 8'(py0);
        width = 9'(pw);
        height = 8'(ph);
        fill_color = 3'(pc);
      end
      if (k == pk_until + 1) start = 1'b0;
      if (k <= n) begin
        e = {9'b0, 3'b100, 9'(exp_q[k-1].x),
             8'(exp_q[k-1].y), 3'(ac)};
        m = ALL;
      end else if (k == n + 1) begin
        e = S_DON;
        m = CTL;
      end else begin
        e = S_IDL;
        m = CTL;
      end
      chk($sformatf("%s cyc%0d", tag, k), outs(), e, m);
      if (wr_en) begin
        if (obs_n == 0) begin
          obs_fx = int'(x);
          obs_fy = int'(y);
        end
        obs_lx = int'(x);
        obs_ly = int'(y);
        obs_n++;
        if (x < 9'd320) hits[x][y]++;
      end
    end
  endtask

  initial begin
    tbl[0] = '{10, 5, 3, 2, 5, 6, 10, 5, 12, 6};
    tbl[1] = '{318, 238, 5, 4, 2, 4, 318, 238, 319, 239};
    tbl[2] = '{20, 20, 0, 5, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{20, 20, 5, 0, 1, 0, 0, 0, 0, 0};
    tbl[4] = '{320, 10, 4, 4, 7, 0, 0, 0, 0, 0};
    tbl[5] = '{10, 240, 4, 4, 7, 0, 0, 0, 0, 0};
    tbl[6] = '{100, 100, 1, 1, 6, 1, 100, 100, 100, 100};
    tbl[7] = '{7, 3, 1, 5, 4, 5, 7, 3, 7, 7};
    tbl[8] = '{300, 50, 511, 2, 3, 40, 300, 50, 319, 51};
    tbl[9] = '{0, 230, 2, 255, 1, 20, 0, 230, 1, 239};

    reset = 1'b1;
    start = 1'b0;
    x0 = '0;
    y0 = '0;
    width = '0;
    height = '0;
    fill_color = '0;
    #1;
    chk("reset state", outs(), S_IDL, ALL);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post reset", outs(), S_IDL, ALL);

    for (int i = 0; i < 10; i++) begin
      run_req($sformatf("tbl%0d", i), tbl[i].x0, tbl[i].y0, tbl[i].w,
              tbl[i].h, tbl[i].c, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("tbl%0d count", i), 32'(obs_n), 32'(tbl[i].n), ALL);
      if (tbl[i].n > 0) begin
        chk($sformatf("tbl%0d first", i), {16'(obs_fx), 16'(obs_fy)},
            {16'(tbl[i].fx), 16'(tbl[i].fy)}, ALL);
        chk($sformatf("tbl%0d last", i), {16'(obs_lx), 16'(obs_ly)},
            {16'(tbl[i].lx), 16'(tbl[i].ly)}, ALL);
      end
    end

    run_req("busy poke", 40, 30, 10, 1, 3, 3, 3, 0, 0, 50, 50, 7);
    chk("busy poke count", 32'(obs_n), 32'd10, ALL);
    run_req("busy hold", 60, 70, 5, 2, 2, 4, 1000000, 200, 100, 2, 1, 6);
    run_req("held start", 200, 100, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    chk("held start count", 32'(obs_n), 32'd2, ALL);

    x0 = 9'd0;
    y0 = 8'd0;
    width = 9'd20;
    height = 8'd1;
    fill_color = 3'd3;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rst draw cyc%0d", k), outs(),
          {9'b0, 3'b100, 9'(k - 1), 8'd0, 3'd3}, ALL);
    end
    reset = 1'b1;
    #1;
    chk("rst abort", outs(), S_IDL, ALL);
    @(negedge clk);
    chk("rst held", outs(), S_IDL, ALL);
    reset = 1'b0;
    @(negedge clk);
    chk("rst release 1", outs(), S_IDL, ALL);
    @(negedge clk);
    chk("rst release 2", outs(), S_IDL, ALL);
    run_req("after rst", 5, 9, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 30; r++) begin
      run_req($sformatf("rnd%0d", r),
              int'($urandom_range(0, 335)), int'($urandom_range(0, 245)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 7)), 0, 0, 0, 0, 0, 0, 0);
    end

    foreach (hits[i, j]) hits[i][j] = 0;
    run_req("full", 0, 0, 320, 240, 5, 0, 0, 0, 0, 0, 0, 0);
    begin
      int once;
      once = 0;
      foreach (hits[i, j]) if (hits[i][j] == 1) once++;
      chk("full once", 32'(once), 32'd76800, ALL);
      chk("full last", {16'(obs_lx), 16'(obs_ly)},
          {16'd319, 16'd239}, ALL);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rect_fill_writer.md
# rect_fill_writer

Pixel-write engine that fills an axis-aligned rectangle of a single colour into the 320x240, 3-bit-per-pixel frame bitmap. It sits between the game logic and the bitmap/VGA display block and drives that block's `x`, `y`, `color`, `wr_en` write port, one pixel per clock. It handles clipping and empty requests so that callers can issue unconstrained rectangles.

## Interface
- `SCREEN_W`, default 320: bitmap width in pixels; columns at or beyond this value are clipped.
- `SCREEN_H`, default 240: bitmap height in pixels; rows at or beyond this value are clipped.

- `clk`  in  1  user clock; same clock as the bitmap write port.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request valid; accepted only when `start && ready`.
- `ready`  out  1  high only in IDLE.
- `x0`  in  9  left column of the rectangle.
- `y0`  in  8  top row of the rectangle.
- `width`  in  9  number of columns, 0..511.
- `height`  in  8  number of rows, 0..255.
- `fill_color`  in  3  {R,G,B} fill value.
- `x`  out  9  write column (registered).
- `y`  out  8  write row (registered).
- `color`  out  3  write data (registered).
- `wr_en`  out  1  pixel write strobe (registered).
- `done`  out  1  one-cycle pulse after a request finishes.

## Operation
States: IDLE, DRAW, DONE. `ready = (state == IDLE)`.

- **IDLE**
  - On `start`, latch `x0`, `y0` and `fill_color`.
  - Compute clip bounds: `x_end = min(x0 + width, SCREEN_W)` in 10 bits, and `y_end = min(y0 + height, SCREEN_H)` in 9 bits. Do not truncate before the compare.
  - The request is empty if `width == 0`, `height == 0`, `x0 >= SCREEN_W` or `y0 >= SCREEN_H`.
  - Empty request: go to DONE with no writes.
  - Otherwise: load `cx = x0`, `cy = y0` and go to DRAW.
- **DRAW**
  - Each cycle, present `x = cx`, `y = cy`, `color = latched colour` and `wr_en = 1`.
  - Raster order: increment `cx`. When `cx + 1 == x_end`, set `cx = x0` and increment `cy`.
  - When `cx + 1 == x_end` and `cy + 1 == y_end`, this is the last pixel; go to DONE.
- **DONE**
  - `done = 1` for one cycle, `wr_en = 0`, then go to IDLE.
- `start` while not in IDLE is ignored; nothing is latched and nothing is queued.
- Input fields may change freely after the accept cycle.
- Pixel count N equals `(x_end − x0) * (y_end − y0)`. Each pixel in the clipped rectangle is written exactly once, and nothing outside it is written.
- No writes are ever issued with `x >= SCREEN_W` or `y >= SCREEN_H`.

## Timing
- **Reset (asynchronous):**
  - State returns to IDLE.
  - `x`, `y`, `color`, `wr_en` and `done` are 0.
  - `ready` is 1 while in reset and after release.
  - Reset asserted mid-DRAW aborts immediately: `wr_en` drops in the same instant and no `done` pulse is produced.
- **Latency** (accept at cycle 0):
  - First `wr_en` at cycle 1.
  - Last `wr_en` at cycle N.
  - `done` at cycle N+1.
  - `ready` back high at cycle N+2.
- **Empty request:** `done` at cycle 1, `ready` at cycle 2, and no `wr_en`.
- **Back-to-back:** a `start` held high is accepted at cycle N+2. The minimum request period is therefore N+2 cycles.
- **Write throughput:** one pixel per cycle with no bubbles inside a request, including across row wrap.
- **Edge cases:** single pixel (N=1) gives `wr_en` at cycle 1 and `done` at cycle 2. A rectangle one column wide wraps the row every cycle.

## Test plan
- **Basic 3x2 fill:** `x0=10, y0=5, width=3, height=2, fill_color=3'b101`.
  - Required: writes (10,5), (11,5), (12,5), (10,6), (11,6), (12,6) on cycles 1–6, all with `color=5`.
  - Required: `done` on cycle 7 and `ready` on cycle 8.
- **Clipping:** `x0=318, y0=238, width=5, height=4`.
  - Required: exactly 4 writes: (318,238), (319,238), (318,239), (319,239).
  - Required: no write with `x>319` or `y>239`.
- **Empty requests:** `width=0`; `height=0`; `x0=320`; `y0=240` (each separately).
  - Required: zero `wr_en`, `done` at cycle 1 and `ready` at cycle 2 for each.
- **Full screen:** `x0=0, y0=0, width=320, height=240`.
  - Required: 76800 consecutive writes; the last write is (319,239) at cycle 76800; `done` at cycle 76801.
  - Required: a scoreboard confirms every pixel is written once.
- **Start while busy:** during a 10-pixel request, pulse `start` with different parameters.
  - Required: the pulse is ignored and the original 10 writes are unchanged.
  - Then: a held `start` is accepted exactly when `ready` rises.
- **Reset mid-draw:** assert `reset` at pixel 4 of 20.
  - Required: `wr_en`, `x`, `y`, `color` and `done` go to 0 at once, and `ready` is 1.
  - Required: after release, a new 1x1 request completes normally.
